// File: rtl/rps_match_engine.sv
// Stone/paper/scissors match controller: captures per-player moves, resolves rounds,
// keeps running scores and a tie count, and declares a winner at WIN_TARGET round wins.
module rps_match_engine #(
    parameter int unsigned WIN_TARGET = 3,
    parameter int unsigned SCORE_W    = 4,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    input  logic [1:0]         move_p1,
    input  logic               p1_valid,
    input  logic [1:0]         move_p2,
    input  logic               p2_valid,
    output logic [1:0]         round_result,
    output logic               round_forfeit,
    output logic               round_done,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [SCORE_W-1:0] tie_count,
    output logic               match_done,
    output logic [1:0]         match_winner,
    output logic [1:0]         state_o
);

    localparam int unsigned        CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0]    CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] Target  = SCORE_W'(WIN_TARGET);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StWait    = 2'b01,
        StResolve = 2'b10,
        StDone    = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ResTie  = 2'b00,
        ResP1   = 2'b01,
        ResP2   = 2'b10,
        ResVoid = 2'b11
    } res_e;

    state_e             state_q;
    logic [1:0]         mv1_q, mv2_q;
    logic               has1_q, has2_q;
    logic [CntW-1:0]    cnt_q;
    res_e               result_q;
    logic               forfeit_q;
    logic               done_q;
    logic [SCORE_W-1:0] p1_score_q, p2_score_q, tie_q;
    logic [1:0]         winner_q;

    logic               cap1, cap2, held1_d, held2_d, first_cap, timeout_hit;
    logic               p1_beats, forfeit;
    res_e               res;
    logic [SCORE_W-1:0] p1_inc, p2_inc;

    always_comb begin
        cap1        = p1_valid & ~has1_q;
        cap2        = p2_valid & ~has2_q;
        held1_d     = has1_q | cap1;
        held2_d     = has2_q | cap2;
        first_cap   = ~has1_q & ~has2_q & (cap1 | cap2);
        // A strobe landing on the expiry edge completes the pair, so no forfeit then.
        timeout_hit = (TIMEOUT != 0) && (has1_q ^ has2_q) && !(held1_d && held2_d)
                      && (cnt_q == CntLast);
        p1_inc      = p1_score_q + SCORE_W'(1);
        p2_inc      = p2_score_q + SCORE_W'(1);
    end

    always_comb begin
        p1_beats = ((mv1_q == 2'd0) && (mv2_q == 2'd2)) ||
                   ((mv1_q == 2'd1) && (mv2_q == 2'd0)) ||
                   ((mv1_q == 2'd2) && (mv2_q == 2'd1));
        forfeit  = has1_q ^ has2_q;
        if (has1_q && !has2_q) begin
            res = ResP1;
        end else if (!has1_q && has2_q) begin
            res = ResP2;
        end else if ((mv1_q == 2'b11) && (mv2_q == 2'b11)) begin
            res = ResVoid;
        end else if (mv1_q == 2'b11) begin
            res = ResP2;
        end else if (mv2_q == 2'b11) begin
            res = ResP1;
        end else if (mv1_q == mv2_q) begin
            res = ResTie;
        end else if (p1_beats) begin
            res = ResP1;
        end else begin
            res = ResP2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mv1_q      <= '0;
            mv2_q      <= '0;
            has1_q     <= 1'b0;
            has2_q     <= 1'b0;
            cnt_q      <= '0;
            result_q   <= ResTie;
            forfeit_q  <= 1'b0;
            done_q     <= 1'b0;
            p1_score_q <= '0;
            p2_score_q <= '0;
            tie_q      <= '0;
            winner_q   <= 2'b00;
        end else if (!ena) begin
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StWait;
                        p1_score_q <= '0;
                        p2_score_q <= '0;
                        tie_q      <= '0;
                        winner_q   <= 2'b00;
                    end
                end
                StWait: begin
                    if (cap1) begin
                        mv1_q  <= move_p1;
                        has1_q <= 1'b1;
                    end
                    if (cap2) begin
                        mv2_q  <= move_p2;
                        has2_q <= 1'b1;
                    end
                    if (first_cap) begin
                        cnt_q <= '0;
                    end else if (has1_q ^ has2_q) begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                    if ((held1_d && held2_d) || timeout_hit) begin
                        state_q <= StResolve;
                    end
                end
                StResolve: begin
                    result_q  <= res;
                    forfeit_q <= forfeit;
                    done_q    <= 1'b1;
                    mv1_q     <= '0;
                    mv2_q     <= '0;
                    has1_q    <= 1'b0;
                    has2_q    <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= StWait;
                    unique case (res)
                        ResP1: begin
                            p1_score_q <= p1_inc;
                            if (p1_inc == Target) begin
                                state_q  <= StDone;
                                winner_q <= 2'b01;
                            end
                        end
                        ResP2: begin
                            p2_score_q <= p2_inc;
                            if (p2_inc == Target) begin
                                state_q  <= StDone;
                                winner_q <= 2'b10;
                            end
                        end
                        ResTie: begin
                            if (tie_q != '1) begin
                                tie_q <= tie_q + SCORE_W'(1);
                            end
                        end
                        ResVoid: ;
                    endcase
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign round_result  = result_q;
    assign round_forfeit = forfeit_q;
    assign round_done    = done_q;
    assign p1_score      = p1_score_q;
    assign p2_score      = p2_score_q;
    assign tie_count     = tie_q;
    assign match_done    = (state_q == StDone);
    assign match_winner  = winner_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_rps_match_engine.sv
// Scoreboard bench for rps_match_engine: stimulus pushes expected round outcomes,
// a negedge monitor pops and compares them whenever round_done pulses.
module tb_rps_match_engine;

    logic       clk = 1'b0;
    logic       rst_n, ena, start;
    logic [1:0] move_p1, move_p2;
    logic       p1_valid, p2_valid;
    logic [1:0] round_result;
    logic       round_forfeit, round_done;
    logic [3:0] p1_score, p2_score, tie_count;
    logic       match_done;
    logic [1:0] match_winner, state_o;

    always #5 clk = ~clk;

    rps_match_engine #(
        .WIN_TARGET(3),
        .SCORE_W   (4),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .move_p1      (move_p1),
        .p1_valid     (p1_valid),
        .move_p2      (move_p2),
        .p2_valid     (p2_valid),
        .round_result (round_result),
        .round_forfeit(round_forfeit),
        .round_done   (round_done),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .tie_count    (tie_count),
        .match_done   (match_done),
        .match_winner (match_winner),
        .state_o      (state_o)
    );

    typedef struct {
        int         cyc;
        logic [1:0] res;
        logic       forf;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] tie;
        logic       md;
        logic [1:0] win;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v1, input logic [1:0] m1, input logic v2,
                         input logic [1:0] m2);
        p1_valid = v1;
        move_p1  = m1;
        p2_valid = v2;
        move_p2  = m2;
        tick();
        p1_valid = 1'b0;
        p2_valid = 1'b0;
    endtask

    task automatic push(input int c, input logic [1:0] res, input logic forf,
                        input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] tie,
                        input logic md, input logic [1:0] win);
        exp_t e;
        e.cyc = c; e.res = res; e.forf = forf; e.p1 = p1; e.p2 = p2;
        e.tie = tie; e.md = md; e.win = win;
        sb.push_back(e);
    endtask

    task automatic wait_sb();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    always @(negedge clk) begin
        if (round_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_round_done: got 1 expected 0");
            end else begin
                mon_e = sb.pop_front();
                chk("round_done_cycle", cyc, mon_e.cyc);
                chk("round_result", int'(round_result), int'(mon_e.res));
                chk("round_forfeit", int'(round_forfeit), int'(mon_e.forf));
                chk("p1_score", int'(p1_score), int'(mon_e.p1));
                chk("p2_score", int'(p2_score), int'(mon_e.p2));
                chk("tie_count", int'(tie_count), int'(mon_e.tie));
                chk("match_done", int'(match_done), int'(mon_e.md));
                chk("match_winner", int'(match_winner), int'(mon_e.win));
            end
        end
    end

    initial begin
        rst_n = 1'b0; ena = 1'b1; start = 1'b0;
        move_p1 = 2'b00; move_p2 = 2'b00; p1_valid = 1'b0; p2_valid = 1'b0;
        repeat (2) tick();
        chk("reset_state", int'(state_o), 0);
        chk("reset_p1_score", int'(p1_score), 0);
        chk("reset_result", int'(round_result), 0);
        chk("reset_match_done", int'(match_done), 0);
        chk("reset_round_done", int'(round_done), 0);

        rst_n = 1'b1;
        drive(1'b1, 2'b00, 1'b1, 2'b10);   // strobes in IDLE are ignored
        chk("idle_ignores_moves", int'(state_o), 0);
        start = 1'b1; tick(); start = 1'b0;
        chk("start_to_wait", int'(state_o), 1);

        // R1: stone vs scissors, same cycle
        push(cyc + 2, 2'b01, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 2'b00);
        drive(1'b1, 2'b00, 1'b1, 2'b10);
        wait_sb();
        chk("back_to_wait", int'(state_o), 1);

        // R2: P2 paper first, a later P2 scissors strobe must be ignored, P1 stone
        push(cyc + 5, 2'b10, 1'b0, 4'd1, 4'd1, 4'd0, 1'b0, 2'b00);
        drive(1'b0, 2'b00, 1'b1, 2'b01);
        tick();
        drive(1'b0, 2'b00, 1'b1, 2'b10);
        drive(1'b1, 2'b00, 1'b0, 2'b00);
        wait_sb();

        // R3, R4: paper ties
        push(cyc + 2, 2'b00, 1'b0, 4'd1, 4'd1, 4'd1, 1'b0, 2'b00);
        drive(1'b1, 2'b01, 1'b1, 2'b01);
        wait_sb();
        push(cyc + 2, 2'b00, 1'b0, 4'd1, 4'd1, 4'd2, 1'b0, 2'b00);
        drive(1'b1, 2'b01, 1'b1, 2'b01);
        wait_sb();

        // R5: P1 invalid vs stone; R6: both invalid -> void
        push(cyc + 2, 2'b10, 1'b0, 4'd1, 4'd2, 4'd2, 1'b0, 2'b00);
        drive(1'b1, 2'b11, 1'b1, 2'b00);
        wait_sb();
        push(cyc + 2, 2'b11, 1'b0, 4'd1, 4'd2, 4'd2, 1'b0, 2'b00);
        drive(1'b1, 2'b11, 1'b1, 2'b11);
        wait_sb();

        // R7: P1 only, P2 absent -> forfeit after 8 edges
        push(cyc + 10, 2'b01, 1'b1, 4'd2, 4'd2, 4'd2, 1'b0, 2'b00);
        drive(1'b1, 2'b10, 1'b0, 2'b00);
        wait_sb();

        // R8: P2 arrives exactly on the expiry edge -> normal round, P1 reaches 3
        push(cyc + 10, 2'b01, 1'b0, 4'd3, 4'd2, 4'd2, 1'b1, 2'b01);
        drive(1'b1, 2'b10, 1'b0, 2'b00);
        repeat (7) tick();
        drive(1'b0, 2'b00, 1'b1, 2'b01);
        wait_sb();
        chk("done_state", int'(state_o), 3);

        drive(1'b1, 2'b00, 1'b1, 2'b10);   // ignored in DONE
        repeat (3) tick();
        chk("done_holds_state", int'(state_o), 3);
        chk("done_holds_score", int'(p1_score), 3);
        chk("done_holds_winner", int'(match_winner), 1);

        start = 1'b1; tick(); start = 1'b0;
        chk("restart_state", int'(state_o), 1);
        chk("restart_p1_score", int'(p1_score), 0);
        chk("restart_p2_score", int'(p2_score), 0);
        chk("restart_winner", int'(match_winner), 0);
        chk("restart_match_done", int'(match_done), 0);

        // ena=0 while in RESOLVE stalls the round
        drive(1'b1, 2'b00, 1'b1, 2'b10);
        chk("in_resolve", int'(state_o), 2);
        ena = 1'b0;
        repeat (3) tick();
        chk("stall_resolve", int'(state_o), 2);
        push(cyc + 1, 2'b01, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 2'b00);
        ena = 1'b1;
        wait_sb();

        // Reset mid-WAIT with P1 held discards the captured move
        drive(1'b1, 2'b10, 1'b0, 2'b00);
        chk("wait_one_held", int'(state_o), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midwait_reset_state", int'(state_o), 0);
        chk("midwait_reset_score", int'(p1_score), 0);
        chk("midwait_reset_result", int'(round_result), 0);
        start = 1'b1; tick(); start = 1'b0;
        drive(1'b0, 2'b00, 1'b1, 2'b00);
        tick();
        chk("old_move_discarded", int'(state_o), 1);
        push(cyc + 2, 2'b01, 1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 2'b00);
        drive(1'b1, 2'b01, 1'b0, 2'b00);
        wait_sb();

        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
